gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_irq_pkg.sv | 17 +
 rtl/gpio_irq_if.sv | 31 +++
 rtl/gpio_irq_filter.sv | 53 +++++
 rtl/gpio_irq.sv | 103 ++++++++++
 tb/tb_gpio_irq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt block.
// Register addresses and parameter defaults.
package gpio_irq_pkg;

    localparam int NUM_GPIO_DEF = 16;
    localparam int FILT_LEN_DEF = 4;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ENABLE  = 4'd0;
    localparam logic [ADDR_W-1:0] RISE_EN = 4'd1;
    localparam logic [ADDR_W-1:0] FALL_EN = 4'd2;
    localparam logic [ADDR_W-1:0] PENDING = 4'd3;
    localparam logic [ADDR_W-1:0] LEVEL   = 4'd4;

endpackage

// File: rtl/gpio_irq_if.sv
// Register bus between a host and the GPIO interrupt block.
// Host drives the strobes; the block returns DataRd.
interface gpio_irq_if;
    import gpio_irq_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataRd;
    logic [DATA_W-1:0] DataWr;
    logic              En;
    logic              Rd;
    logic              Wr;

    modport master (
        output Addr,
        output DataWr,
        output En,
        output Rd,
        output Wr,
        input  DataRd
    );

    modport slave (
        input  Addr,
        input  DataWr,
        input  En,
        input  Rd,
        input  Wr,
        output DataRd
    );

endinterface

// File: rtl/gpio_irq_filter.sv
// Per-pin synchronizer, glitch filter and edge detector.
// Until Armed, Filt follows Sync directly.
module gpio_irq_filter
    import gpio_irq_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Armed,
    input  logic Pin,
    output logic Filt,
    output logic Rise,
    output logic Fall
);

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    logic       syncA;
    logic       sync;
    logic       filtD;
    logic [3:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            syncA <= 1'b0;
            sync  <= 1'b0;
            Filt  <= 1'b0;
            filtD <= 1'b0;
            cnt   <= '0;
        end else begin
            syncA <= Pin;
            sync  <= syncA;
            filtD <= Filt;
            if (!Armed) begin
                Filt <= sync;
                cnt  <= '0;
            end else if (sync == Filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                Filt <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Edges are seen one cycle after Filt moves.
    assign Rise = Filt & ~filtD;
    assign Fall = ~Filt & filtD;

endmodule

// File: rtl/gpio_irq.sv
// GPIO edge interrupt controller: filtered pins, enables,
// write-1-to-clear pending bits and a level interrupt.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int NUM_GPIO = NUM_GPIO_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    gpio_irq_if.slave           bus,
    input  logic [NUM_GPIO-1:0] P,
    output logic                Irq
);

    localparam logic [4:0] ARM_LAST = 5'(FILT_LEN + 1);

    logic [NUM_GPIO-1:0] enable;
    logic [NUM_GPIO-1:0] riseEn;
    logic [NUM_GPIO-1:0] fallEn;
    logic [NUM_GPIO-1:0] pending;
    logic [NUM_GPIO-1:0] filtVec;
    logic [NUM_GPIO-1:0] riseVec;
    logic [NUM_GPIO-1:0] fallVec;
    logic [NUM_GPIO-1:0] evt;
    logic [NUM_GPIO-1:0] w1c;
    logic [NUM_GPIO-1:0] wrData;
    logic [NUM_GPIO-1:0] rdVal;
    logic [4:0]          armCnt;
    logic                armed;
    logic                wrHit;
    logic                unusedRd;

    assign unusedRd = bus.Rd;

    for (genvar i = 0; i < NUM_GPIO; i++) begin : gPin
        gpio_irq_filter #(
            .FILT_LEN (FILT_LEN)
        ) uFilt (
            .Clk   (Clk),
            .Reset (Reset),
            .Armed (armed),
            .Pin   (P[i]),
            .Filt  (filtVec[i]),
            .Rise  (riseVec[i]),
            .Fall  (fallVec[i])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            armCnt <= '0;
            armed  <= 1'b0;
        end else if (!armed) begin
            if (armCnt == ARM_LAST) armed <= 1'b1;
            else armCnt <= armCnt + 5'd1;
        end
    end

    assign wrHit  = bus.En & bus.Wr;
    assign wrData = bus.DataWr[NUM_GPIO-1:0];

    assign evt = armed ? ((riseVec & riseEn) | (fallVec & fallEn))
                       : '0;
    assign w1c = (wrHit && bus.Addr == PENDING) ? wrData : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            enable  <= '0;
            riseEn  <= '0;
            fallEn  <= '0;
            pending <= '0;
        end else begin
            // A new event beats a same-cycle clear.
            pending <= (pending & ~w1c) | evt;
            if (wrHit) begin
                case (bus.Addr)
                    ENABLE:  enable <= wrData;
                    RISE_EN: riseEn <= wrData;
                    FALL_EN: fallEn <= wrData;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdVal = '0;
        case (bus.Addr)
            ENABLE:  rdVal = enable;
            RISE_EN: rdVal = riseEn;
            FALL_EN: rdVal = fallEn;
            PENDING: rdVal = pending;
            LEVEL:   rdVal = filtVec;
            default: rdVal = '0;
        endcase
        bus.DataRd = '0;
        bus.DataRd[NUM_GPIO-1:0] = rdVal;
    end

    assign Irq = |(pending & enable);

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq with a window-based
// reference model compared on every cycle.
module tb_gpio_irq;
    import gpio_irq_pkg::*;

    localparam int NG = 16;
    localparam int FL = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] P = '0;
    logic        Irq;

    gpio_irq_if bus ();

    gpio_irq #(
        .NUM_GPIO (NG),
        .FILT_LEN (FL)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus),
        .P     (P),
        .Irq   (Irq)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            if (nErrors < 40)
                $display("FAIL %s: got %h want %h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    // Reference model: a pin is accepted once its last FL
    // synchronized samples all disagree with the filtered value.
    logic [15:0] mEn, mRise, mFall, mPend;
    logic [15:0] mFilt, mFiltOld, mSyncA, mSync;
    logic [15:0] mHist [16];
    int          mEdges;
    bit          mArmed;
    bit          started = 0;

    function automatic bit allEq(input logic [15:0] h, input logic v);
        logic [15:0] mask;
        mask = 16'((1 << FL) - 1);
        return (h & mask) == (v ? mask : 16'h0);
    endfunction

    always @(posedge Clk) begin
        logic [15:0] evt;
        logic [15:0] w1c;
        logic [15:0] nf;
        if (Reset) begin
            {mEn, mRise, mFall, mPend} = '0;
            {mFilt, mFiltOld, mSyncA, mSync} = '0;
            for (int i = 0; i < 16; i++) mHist[i] = '0;
            mEdges = 0;
            mArmed = 0;
            started = 1;
        end else begin
            evt = '0;
            if (mArmed)
                evt = (mFilt & ~mFiltOld & mRise)
                    | (~mFilt & mFiltOld & mFall);
            w1c = '0;
            if (bus.En && bus.Wr && bus.Addr == 4'd3)
                w1c = bus.DataWr;
            mPend = (mPend & ~w1c) | evt;
            if (bus.En && bus.Wr) begin
                if (bus.Addr == 4'd0) mEn = bus.DataWr;
                if (bus.Addr == 4'd1) mRise = bus.DataWr;
                if (bus.Addr == 4'd2) mFall = bus.DataWr;
            end
            nf = mFilt;
            for (int i = 0; i < 16; i++) begin
                mHist[i] = {mHist[i][14:0], mSync[i]};
                if (!mArmed) nf[i] = mSync[i];
                else if (allEq(mHist[i], ~mFilt[i])) nf[i] = ~mFilt[i];
            end
            mFiltOld = mFilt;
            mFilt = nf;
            mSync = mSyncA;
            mSyncA = P;
            mEdges++;
            mArmed = (mEdges >= FL + 2);
        end
    end

    function automatic logic [15:0] modelRd(input logic [3:0] a);
        case (a)
            4'd0: return mEn;
            4'd1: return mRise;
            4'd2: return mFall;
            4'd3: return mPend;
            4'd4: return mFilt;
            default: return 16'h0;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (started) begin
            check("cmpRd", bus.DataRd, modelRd(bus.Addr));
            check("cmpIrq", {15'b0, Irq}, {15'b0, |(mPend & mEn)});
        end
    end

    logic [3:0] ra [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9};

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.Addr = ra[k % 6];
            tick();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.Addr = a;
        bus.DataWr = d;
        bus.En = 1'b1;
        bus.Wr = 1'b1;
        tick();
        bus.En = 1'b0;
        bus.Wr = 1'b0;
        bus.DataWr = '0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp,
                      input string nm);
        bus.Addr = a;
        bus.Rd = 1'b1;
        #1;
        check(nm, bus.DataRd, exp);
        bus.Rd = 1'b0;
    endtask

    task automatic chkIrq(input logic exp, input string nm);
        check(nm, {15'b0, Irq}, {15'b0, exp});
    endtask

    initial begin
        bus.Addr = '0;
        bus.DataWr = '0;
        bus.En = 1'b0;
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        rd(4'd0, 16'h0, "rstEnable");
        rd(4'd3, 16'h0, "rstPending");
        rd(4'd4, 16'h0, "rstLevel");
        chkIrq(1'b0, "rstIrq");
        idle(10);

        // Pin 3 rising edge through the filter.
        wr(4'd1, 16'h0008);
        wr(4'd0, 16'h0008);
        P[3] = 1'b1;
        repeat (5) tick();
        rd(4'd4, 16'h0000, "lvlEdge5");
        tick();
        rd(4'd4, 16'h0008, "lvlEdge6");
        rd(4'd3, 16'h0000, "pendEdge6");
        tick();
        rd(4'd3, 16'h0008, "pendEdge7");
        chkIrq(1'b1, "irqPin3");
        wr(4'd3, 16'h0008);
        rd(4'd3, 16'h0000, "pendW1c");
        chkIrq(1'b0, "irqCleared");

        // Ignored writes, short and just-long-enough pulses.
        wr(4'd9, 16'hFFFF);
        wr(4'd4, 16'hFFFF);
        rd(4'd9, 16'h0000, "rsvdRead");
        rd(4'd4, 16'h0008, "lvlNoWrite");
        wr(4'd1, 16'h0020);
        wr(4'd2, 16'h0020);
        P[5] = 1'b1;
        repeat (3) tick();
        P[5] = 1'b0;
        idle(10);
        rd(4'd3, 16'h0000, "pendGlitch");
        rd(4'd4, 16'h0008, "lvlGlitch");
        P[5] = 1'b1;
        repeat (4) tick();
        P[5] = 1'b0;
        idle(12);
        rd(4'd3, 16'h0020, "pendPulse4");
        wr(4'd3, 16'h0020);

        // Same-edge clear and falling event on pin 0.
        wr(4'd2, 16'h0021);
        P[0] = 1'b1;
        idle(10);
        rd(4'd3, 16'h0000, "pendNoRise0");
        P[0] = 1'b0;
        repeat (6) tick();
        wr(4'd3, 16'h0001);
        rd(4'd3, 16'h0001, "pendSetWins");
        wr(4'd3, 16'h0001);
        rd(4'd3, 16'h0000, "pendClr0");

        // Pending is independent of Enable.
        wr(4'd0, 16'h0000);
        wr(4'd1, 16'h0080);
        P[7] = 1'b1;
        idle(10);
        rd(4'd3, 16'h0080, "pendMasked");
        chkIrq(1'b0, "irqMasked");
        wr(4'd0, 16'h0080);
        chkIrq(1'b1, "irqUnmasked");

        // Fill Pending, then reset.
        wr(4'd1, 16'h00FF);
        P = 16'h0077;
        idle(10);
        rd(4'd3, 16'h00F7, "pendF7");
        P = 16'h00FF;
        idle(10);
        rd(4'd3, 16'h00FF, "pendFF");
        wr(4'd0, 16'h00FF);
        chkIrq(1'b1, "irqFF");
        Reset = 1'b1;
        tick();
        rd(4'd0, 16'h0, "rstEn2");
        rd(4'd1, 16'h0, "rstRise2");
        rd(4'd2, 16'h0, "rstFall2");
        rd(4'd3, 16'h0, "rstPend2");
        rd(4'd9, 16'h0, "rstRsvd2");
        chkIrq(1'b0, "rstIrq2");

        // Pins high through reset: no rising events.
        P = 16'hFFFF;
        tick();
        Reset = 1'b0;
        repeat (2) tick();
        rd(4'd4, 16'h0000, "lvlUnarmed2");
        tick();
        rd(4'd4, 16'hFFFF, "lvlUnarmed3");
        wr(4'd1, 16'hFFFF);
        idle(20);
        rd(4'd3, 16'h0000, "pendHeldHigh");
        rd(4'd4, 16'hFFFF, "lvlHeldHigh");

        // Reset in the middle of filtering.
        wr(4'd2, 16'hFFFF);
        P = 16'h0000;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        idle(12);
        rd(4'd3, 16'h0000, "pendMidFilt");
        rd(4'd4, 16'h0000, "lvlMidFilt");

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule
